ram_ctrl: RTL and testbench

//  Initiator for the single-port parity RAM (ram). Accepts read/write requests on a valid/ready host port
//  and drives the RAM's wr_en/rd_en/blk_select/addr_en/dout_en. It sequences the RAM's address and

---
 rtl/ram_ctrl_pkg.sv | 16 +
 rtl/ram.sv | 42 ++++
 rtl/ram_ctrl.sv | 158 +++++++++++++++
 tb/tb_ram_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the parity RAM initiator: FSM encoding and error-counter helpers.
package ram_ctrl_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    localparam int unsigned PERR_CNT_W = 8;

    function automatic logic [PERR_CNT_W-1:0] sat_inc(input logic [PERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ram.sv
// Single-port RAM with optional address/output pipeline registers and odd parity on dout.
module ram #(
    parameter int unsigned MEM_WIDTH     = 16,
    parameter int unsigned ADDR_SIZE     = 10,
    parameter string       ADDR_PIPELINE = "FALSE",
    parameter string       DOUT_PIPELINE = "TRUE"
) (
    input  logic                 clk_i,
    input  logic [MEM_WIDTH-1:0] din_i,
    input  logic [ADDR_SIZE-1:0] addr_i,
    input  logic                 wr_en_i,
    input  logic                 rd_en_i,
    input  logic                 blk_select_i,
    input  logic                 addr_en_i,
    input  logic                 dout_en_i,
    output logic [MEM_WIDTH-1:0] dout_o,
    output logic                 parity_out_o
);

    localparam bit AP = (ADDR_PIPELINE == "TRUE");
    localparam bit DP = (DOUT_PIPELINE == "TRUE");
    localparam int unsigned DEPTH = 1 << ADDR_SIZE;

    logic [MEM_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_SIZE-1:0] addr_reg_q;
    logic [ADDR_SIZE-1:0] addr_eff;
    logic [MEM_WIDTH-1:0] rd_data_q;
    logic [MEM_WIDTH-1:0] dout_q;

    assign addr_eff = AP ? addr_reg_q : addr_i;

    always_ff @(posedge clk_i) begin
        if (addr_en_i) addr_reg_q <= addr_i;
        if (blk_select_i && wr_en_i) mem_q[addr_eff] <= din_i;
        if (blk_select_i && rd_en_i) rd_data_q <= mem_q[addr_eff];
        if (dout_en_i) dout_q <= rd_data_q;
    end

    assign dout_o       = DP ? dout_q : rd_data_q;
    assign parity_out_o = ~^dout_o;

endmodule

// File: rtl/ram_ctrl.sv
// Host-side initiator for the parity RAM: sequences address/dout pipeline stages,
// captures read data, checks parity and returns read responses over valid/ready.
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WIDTH     = 16,
    parameter int unsigned ADDR_SIZE     = 10,
    parameter string       ADDR_PIPELINE = "FALSE",
    parameter string       DOUT_PIPELINE = "TRUE",
    parameter bit          PARITY_ENABLE = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_wr_i,
    input  logic [ADDR_SIZE-1:0]  req_addr_i,
    input  logic [MEM_WIDTH-1:0]  req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [MEM_WIDTH-1:0]  rsp_data_o,
    output logic                  rsp_perr_o,
    output logic [PERR_CNT_W-1:0] perr_cnt_o,
    output logic [MEM_WIDTH-1:0]  ram_din_o,
    output logic [ADDR_SIZE-1:0]  ram_addr_o,
    output logic                  ram_wr_en_o,
    output logic                  ram_rd_en_o,
    output logic                  ram_blk_select_o,
    output logic                  ram_addr_en_o,
    output logic                  ram_dout_en_o,
    input  logic [MEM_WIDTH-1:0]  ram_dout_i,
    input  logic                  ram_parity_out_i
);

    localparam bit AP = (ADDR_PIPELINE == "TRUE");
    localparam bit DP = (DOUT_PIPELINE == "TRUE");

    logic [2:0]            state_q, state_d;
    logic [1:0]            wait_q, wait_d;
    logic                  wr_q, wr_d;
    logic [ADDR_SIZE-1:0]  addr_q, addr_d;
    logic [MEM_WIDTH-1:0]  din_q, din_d;
    logic [MEM_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                  rsp_perr_q, rsp_perr_d;
    logic [PERR_CNT_W-1:0] perr_cnt_q, perr_cnt_d;
    logic                  perr_now;

    logic req_ready_q, req_ready_d;
    logic rsp_valid_q, rsp_valid_d;
    logic wr_en_q, wr_en_d;
    logic rd_en_q, rd_en_d;
    logic blk_q, blk_d;
    logic addr_en_q, addr_en_d;
    logic dout_en_q, dout_en_d;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        din_d      = din_q;
        rsp_data_d = rsp_data_q;
        rsp_perr_d = rsp_perr_q;
        perr_cnt_d = perr_cnt_q;
        perr_now   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    wr_d    = req_wr_i;
                    addr_d  = req_addr_i;
                    din_d   = req_wdata_i;
                    state_d = AP ? S_ADDR : S_ACCESS;
                end
            end
            S_ADDR: state_d = S_ACCESS;
            S_ACCESS: begin
                state_d = wr_q ? S_IDLE : S_WAIT;
                wait_d  = {1'b0, DP};
            end
            S_WAIT: begin
                if (wait_q == 2'd0) begin
                    // Last wait cycle: dout is valid at this edge.
                    state_d    = S_RESP;
                    perr_now   = PARITY_ENABLE && (ram_parity_out_i != ~^ram_dout_i);
                    rsp_data_d = ram_dout_i;
                    rsp_perr_d = perr_now;
                    if (perr_now) perr_cnt_d = sat_inc(perr_cnt_q);
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            S_RESP: begin
                if (rsp_valid_q && rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        req_ready_d = (state_d == S_IDLE);
        blk_d       = (state_d == S_ACCESS);
        wr_en_d     = blk_d && wr_d;
        rd_en_d     = blk_d && !wr_d;
        addr_en_d   = (state_d == S_ADDR) || (state_d == S_ACCESS);
        dout_en_d   = DP && (state_d == S_WAIT) && (wait_d != 2'd0);
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            wait_q      <= 2'd0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            rsp_data_q  <= '0;
            rsp_perr_q  <= 1'b0;
            perr_cnt_q  <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            blk_q       <= 1'b0;
            addr_en_q   <= 1'b0;
            dout_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            rsp_data_q  <= rsp_data_d;
            rsp_perr_q  <= rsp_perr_d;
            perr_cnt_q  <= perr_cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            blk_q       <= blk_d;
            addr_en_q   <= addr_en_d;
            dout_en_q   <= dout_en_d;
        end
    end

    assign req_ready_o      = req_ready_q;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_data_o       = rsp_data_q;
    assign rsp_perr_o       = rsp_perr_q;
    assign perr_cnt_o       = perr_cnt_q;
    assign ram_din_o        = din_q;
    assign ram_addr_o       = addr_q;
    assign ram_wr_en_o      = wr_en_q;
    assign ram_rd_en_o      = rd_en_q;
    assign ram_blk_select_o = blk_q;
    assign ram_addr_en_o    = addr_en_q;
    assign ram_dout_en_o    = dout_en_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: three controller+RAM pairs (default, address-pipelined, parity off)
// driven by directed steps with a response scoreboard.
module tb_ram_ctrl;

    localparam int MW = 16;
    localparam int AW = 10;
    localparam int N  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rst_n       [N];
    logic          req_valid   [N];
    logic          req_ready   [N];
    logic          req_wr      [N];
    logic [AW-1:0] req_addr    [N];
    logic [MW-1:0] req_wdata   [N];
    logic          rsp_valid   [N];
    logic          rsp_ready   [N];
    logic [MW-1:0] rsp_data    [N];
    logic          rsp_perr    [N];
    logic [7:0]    perr_cnt    [N];
    logic [MW-1:0] ram_din     [N];
    logic [AW-1:0] ram_addr    [N];
    logic          ram_wr_en   [N];
    logic          ram_rd_en   [N];
    logic          ram_blk     [N];
    logic          ram_addr_en [N];
    logic          ram_dout_en [N];
    logic [MW-1:0] ram_dout    [N];
    logic          ram_par     [N];
    logic          par_flip    [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam string APS = (g == 1) ? "TRUE" : "FALSE";
        localparam string DPS = (g == 1) ? "FALSE" : "TRUE";
        logic par_raw;

        ram_ctrl #(
            .MEM_WIDTH    (MW),
            .ADDR_SIZE    (AW),
            .ADDR_PIPELINE(APS),
            .DOUT_PIPELINE(DPS),
            .PARITY_ENABLE(g != 2)
        ) u_ctrl (
            .clk_i           (clk),
            .rst_ni          (rst_n[g]),
            .req_valid_i     (req_valid[g]),
            .req_ready_o     (req_ready[g]),
            .req_wr_i        (req_wr[g]),
            .req_addr_i      (req_addr[g]),
            .req_wdata_i     (req_wdata[g]),
            .rsp_valid_o     (rsp_valid[g]),
            .rsp_ready_i     (rsp_ready[g]),
            .rsp_data_o      (rsp_data[g]),
            .rsp_perr_o      (rsp_perr[g]),
            .perr_cnt_o      (perr_cnt[g]),
            .ram_din_o       (ram_din[g]),
            .ram_addr_o      (ram_addr[g]),
            .ram_wr_en_o     (ram_wr_en[g]),
            .ram_rd_en_o     (ram_rd_en[g]),
            .ram_blk_select_o(ram_blk[g]),
            .ram_addr_en_o   (ram_addr_en[g]),
            .ram_dout_en_o   (ram_dout_en[g]),
            .ram_dout_i      (ram_dout[g]),
            .ram_parity_out_i(ram_par[g])
        );

        ram #(
            .MEM_WIDTH    (MW),
            .ADDR_SIZE    (AW),
            .ADDR_PIPELINE(APS),
            .DOUT_PIPELINE(DPS)
        ) u_ram (
            .clk_i       (clk),
            .din_i       (ram_din[g]),
            .addr_i      (ram_addr[g]),
            .wr_en_i     (ram_wr_en[g]),
            .rd_en_i     (ram_rd_en[g]),
            .blk_select_i(ram_blk[g]),
            .addr_en_i   (ram_addr_en[g]),
            .dout_en_i   (ram_dout_en[g]),
            .dout_o      (ram_dout[g]),
            .parity_out_o(par_raw)
        );

        assign ram_par[g] = par_raw ^ par_flip[g];
    end

    typedef struct {
        int            inst;
        logic [MW-1:0] data;
        logic          perr;
    } exp_t;

    exp_t          sb[$];
    logic [MW-1:0] mdl [N][1 << AW];
    int            n_vec = 0;
    int            n_err = 0;

    function automatic int ap(int i);
        return (i == 1) ? 1 : 0;
    endfunction
    function automatic int dp(int i);
        return (i == 1) ? 0 : 1;
    endfunction
    function automatic logic pe(int i);
        return (i != 2);
    endfunction

    task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the handshake cycle with valid still high.
    task automatic send(int i, logic wr, logic [AW-1:0] addr, logic [MW-1:0] data, output int h);
        req_valid[i] = 1'b1;
        req_wr[i]    = wr;
        req_addr[i]  = addr;
        req_wdata[i] = data;
        h = -1;
        for (int n = 0; n < 20; n++) begin
            if (req_ready[i]) begin
                h = cyc;
                break;
            end
            @(negedge clk);
        end
        if (h < 0) chk("hs_timeout", i, 0, 1);
    endtask

    task automatic do_write(int i, logic [AW-1:0] addr, logic [MW-1:0] data);
        int h;
        int n_wr = 0;
        send(i, 1'b1, addr, data, h);
        mdl[i][addr] = data;
        @(negedge clk);
        req_valid[i] = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (req_ready[i]) break;
            if (ram_wr_en[i]) begin
                n_wr++;
                chk("wr_addr", i, 32'(ram_addr[i]), 32'(addr));
                chk("wr_din", i, 32'(ram_din[i]), 32'(data));
            end
            @(negedge clk);
        end
        chk("wr_ready_lat", i, cyc - h, 2 + ap(i));
        chk("wr_en_cycles", i, n_wr, 1);
    endtask

    task automatic do_read(int i, logic [AW-1:0] addr, int hold, logic flip, logic poke);
        int            h;
        int            first_rv = -1;
        int            first_ae = -1;
        int            first_rd = -1;
        int            n_de     = 0;
        int            held     = 0;
        bit            done     = 0;
        logic [MW-1:0] d0;
        logic          p0;
        exp_t          e;
        par_flip[i]  = flip;
        rsp_ready[i] = (hold == 0);
        send(i, 1'b0, addr, '0, h);
        e.inst = i;
        e.data = mdl[i][addr];
        e.perr = flip && pe(i);
        sb.push_back(e);
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (n == 0) req_valid[i] = 1'b0;
            if (ram_addr_en[i] && first_ae < 0) first_ae = cyc;
            if (ram_rd_en[i] && first_rd < 0) first_rd = cyc;
            if (ram_dout_en[i]) n_de++;
            if (rsp_valid[i]) begin
                if (first_rv < 0) begin
                    first_rv = cyc;
                    d0       = rsp_data[i];
                    p0       = rsp_perr[i];
                end else begin
                    chk("rsp_stable", i, {15'd0, rsp_data[i], rsp_perr[i]}, {15'd0, d0, p0});
                    chk("ready_low_resp", i, 32'(req_ready[i]), 0);
                end
                if (!rsp_ready[i]) begin
                    if (held == hold) begin
                        rsp_ready[i] = 1'b1;
                    end else begin
                        held++;
                        if (poke) begin
                            req_valid[i] = 1'b1;
                            req_wr[i]    = 1'b1;
                            req_addr[i]  = 10'h006;
                            req_wdata[i] = 16'hDEAD;
                        end
                    end
                end
                if (rsp_ready[i]) begin
                    req_valid[i] = 1'b0;
                    done = 1;
                    if (sb.size() == 0) begin
                        chk("sb_empty", i, 0, 1);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_inst", i, i, e.inst);
                        chk("rsp_data", i, 32'(rsp_data[i]), 32'(e.data));
                        chk("rsp_perr", i, 32'(rsp_perr[i]), 32'(e.perr));
                    end
                end
            end
        end
        rsp_ready[i] = 1'b1;
        par_flip[i]  = 1'b0;
        if (!done) chk("rsp_timeout", i, 0, 1);
        chk("rsp_lat", i, first_rv - h, 3 + ap(i) + dp(i));
        chk("dout_en_cycles", i, n_de, dp(i));
        chk("held_cycles", i, held, hold);
        if (ap(i) == 1) chk("ae_before_rd", i, first_rd - first_ae, 1);
    endtask

    task automatic chk_idle(int i, string tag);
        chk({tag, "_ready"}, i, 32'(req_ready[i]), 1);
        chk({tag, "_en"}, i,
            {27'd0, ram_wr_en[i], ram_rd_en[i], ram_blk[i], ram_addr_en[i], ram_dout_en[i]}, 0);
        chk({tag, "_rsp_valid"}, i, 32'(rsp_valid[i]), 0);
        chk({tag, "_perr_cnt"}, i, 32'(perr_cnt[i]), 0);
    endtask

    initial begin
        int            h;
        int            n_rv;
        logic [AW-1:0] ra;
        logic [MW-1:0] rd;
        for (int i = 0; i < N; i++) begin
            rst_n[i]     = 1'b0;
            req_valid[i] = 1'b0;
            req_wr[i]    = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            rsp_ready[i] = 1'b1;
            par_flip[i]  = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) chk_idle(i, "reset");
        for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
        @(negedge clk);

        for (int i = 0; i < N; i++) begin
            do_write(i, 10'h005, 16'hA5A5);
            do_read(i, 10'h005, 0, 1'b0, 1'b0);
            do_write(i, 10'h3FF, 16'h0001);
            do_read(i, 10'h3FF, 0, 1'b0, 1'b0);
            do_write(i, 10'h006, 16'h1234);
            do_read(i, 10'h005, 5, 1'b0, 1'b1);
            do_read(i, 10'h006, 0, 1'b0, 1'b0);
            for (int k = 0; k < 3; k++) do_read(i, 10'h3FF, 0, 1'b1, 1'b0);
            chk("perr_cnt", i, 32'(perr_cnt[i]), pe(i) ? 3 : 0);
            do_read(i, 10'h005, 0, 1'b0, 1'b0);
            chk("perr_cnt_hold", i, 32'(perr_cnt[i]), pe(i) ? 3 : 0);
            for (int k = 0; k < 3; k++) begin
                ra = AW'($urandom_range(0, (1 << AW) - 1));
                rd = MW'($urandom);
                do_write(i, ra, rd);
                do_read(i, ra, k, 1'b0, 1'b0);
            end
        end

        // Reset in the first WAIT cycle abandons the read.
        send(0, 1'b0, 10'h005, '0, h);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("wait_dout_en", 0, 32'(ram_dout_en[0]), 1);
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        chk_idle(0, "midrst");
        n_rv = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid[0]) n_rv++;
        end
        chk("midrst_no_rsp", 0, n_rv, 0);
        do_read(0, 10'h005, 0, 1'b0, 1'b0);
        chk("sb_drained", 0, sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
